// File: rtl/sonar_scheduler_pkg.sv
// Shared definitions for the sonar scheduler: FSM state encoding, the
// distance error code and the default echo-microseconds-per-centimetre ratio.
package sonar_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    REPORT,
    HOLD
  } state_t;

  // Reported distance for timeout or overrange.
  localparam logic [11:0] DIST_ERR = 12'hFFF;
  // Largest distance the cm counter may reach, so a genuine measurement
  // can never alias onto DIST_ERR.
  localparam logic [11:0] CM_MAX = 12'hFFE;
  localparam int US_PER_CM_DEFAULT = 58;

endpackage

// File: rtl/sonar_scheduler_echo_timer.sv
// Echo timer shared by all sensors. It watches the selected, synchronised
// echo line and its one-cycle-delayed copy.
//   clk_1m, rst    : 1 MHz clock, asynchronous active-high reset
//   echo_sync      : selected channel, synchronised
//   echo_prev      : selected channel, synchronised and delayed one cycle
//   wait_en        : scheduler is waiting for the echo rise
//   meas_en        : scheduler is timing the echo high width
//   rise, fall     : edges on the selected channel
//   timeout        : no rise seen within RISE_TIMEOUT_US cycles (rise wins)
//   overrange      : echo high for ECHO_MAX_US cycles (fall wins)
//   cm             : whole centimetres measured so far
module echo_timer
  import sonar_scheduler_pkg::*;
#(
  parameter int RISE_TIMEOUT_US = 30000,
  parameter int ECHO_MAX_US     = 25000,
  parameter int US_PER_CM       = US_PER_CM_DEFAULT
) (
  input  logic        clk_1m,
  input  logic        rst,
  input  logic        echo_sync,
  input  logic        echo_prev,
  input  logic        wait_en,
  input  logic        meas_en,
  output logic        rise,
  output logic        fall,
  output logic        timeout,
  output logic        overrange,
  output logic [11:0] cm
);

  localparam logic [14:0] WAIT_LAST = 15'(RISE_TIMEOUT_US - 1);
  localparam logic [14:0] HIGH_LAST = 15'(ECHO_MAX_US - 1);
  localparam logic [5:0]  SUB_LAST  = 6'(US_PER_CM - 1);

  // wait_cnt counts rise-wait cycles in WAIT_RISE and echo-high cycles in
  // MEASURE; the rise clears it so one counter serves both limits.
  logic [14:0] wait_cnt_reg;
  logic [5:0]  us_sub_reg;
  logic [11:0] cm_reg;

  assign rise      = echo_sync & ~echo_prev;
  assign fall      = ~echo_sync & echo_prev;
  assign timeout   = wait_en & ~rise & (wait_cnt_reg == WAIT_LAST);
  assign overrange = meas_en & ~fall & (wait_cnt_reg == HIGH_LAST);
  assign cm        = cm_reg;

  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      us_sub_reg   <= '0;
      cm_reg       <= '0;
    end else if (wait_en) begin
      if (rise) begin
        wait_cnt_reg <= '0;
        us_sub_reg   <= '0;
        cm_reg       <= '0;
      end else begin
        wait_cnt_reg <= wait_cnt_reg + 15'd1;
      end
    end else if (meas_en) begin
      // The fall cycle also counts, so the total equals the echo width.
      wait_cnt_reg <= wait_cnt_reg + 15'd1;
      if (us_sub_reg == SUB_LAST) begin
        us_sub_reg <= '0;
        if (cm_reg != CM_MAX) begin
          cm_reg <= cm_reg + 12'd1;
        end
      end else begin
        us_sub_reg <= us_sub_reg + 6'd1;
      end
    end else if (!meas_en) begin
      // Outside WAIT_RISE/MEASURE hold wait_cnt at zero for the next slot;
      // cm is left alone so REPORT can still read it.
      wait_cnt_reg <= '0;
    end
  end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler for up to four HC-SR04-style rangers sharing one
// echo timer. Each slot lasts exactly CYCLE_US cycles: trigger, wait for
// the echo rise, time the echo, report, then hold until the slot ends.
//   clk_1m     : 1 MHz clock (1 cycle = 1 us)
//   rst        : asynchronous active-high reset
//   enable     : run the rotation while high
//   echo       : raw asynchronous echo inputs, one per sensor
//   trig       : registered trigger outputs
//   dist_cm    : last distance in cm, 12'hFFF on timeout/overrange
//   dist_sel   : sensor index of dist_cm
//   dist_valid : one-cycle strobe when dist_cm/dist_sel update
//   dist_err   : one-cycle strobe with dist_valid for an error result
//   busy       : high whenever the scheduler is not IDLE
module sonar_scheduler
  import sonar_scheduler_pkg::*;
#(
  parameter int NUM_SENSORS     = 2,
  parameter int TRIG_US         = 10,
  parameter int CYCLE_US        = 60000,
  parameter int RISE_TIMEOUT_US = 30000,
  parameter int ECHO_MAX_US     = 25000,
  parameter int US_PER_CM       = US_PER_CM_DEFAULT
) (
  input  logic                   clk_1m,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [11:0]            dist_cm,
  output logic [1:0]             dist_sel,
  output logic                   dist_valid,
  output logic                   dist_err,
  output logic                   busy
);

  localparam logic [15:0] TRIG_LAST  = 16'(TRIG_US - 1);
  localparam logic [15:0] CYCLE_LAST = 16'(CYCLE_US - 1);
  localparam logic [1:0]  SEL_LAST   = 2'(NUM_SENSORS - 1);

  state_t state_reg, state_next;
  logic [15:0] cycle_cnt_reg, cycle_cnt_next;
  logic [1:0]  sel_reg, sel_next;
  logic        err_flag_reg, err_flag_next;

  logic [NUM_SENSORS-1:0] sync1_reg, sync2_reg, delay_reg;
  logic [NUM_SENSORS-1:0] trig_reg, trig_next;
  logic [11:0] dist_cm_reg;
  logic [1:0]  dist_sel_reg;
  logic        dist_valid_reg, dist_err_reg;

  logic [3:0] sync_pad, delay_pad;
  logic       rise, fall, timeout, overrange;
  logic [11:0] cm;

  // Two-flop synchroniser plus a delay stage per channel. Edge detection
  // uses the selected channel's own delayed copy, so switching sel never
  // manufactures an edge from another sensor's level.
  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      delay_reg <= '0;
    end else begin
      sync1_reg <= echo;
      sync2_reg <= sync1_reg;
      delay_reg <= sync2_reg;
    end
  end

  always_comb begin
    sync_pad  = '0;
    delay_pad = '0;
    sync_pad[NUM_SENSORS-1:0]  = sync2_reg;
    delay_pad[NUM_SENSORS-1:0] = delay_reg;
  end

  echo_timer #(
    .RISE_TIMEOUT_US(RISE_TIMEOUT_US),
    .ECHO_MAX_US    (ECHO_MAX_US),
    .US_PER_CM      (US_PER_CM)
  ) u_echo_timer (
    .clk_1m   (clk_1m),
    .rst      (rst),
    .echo_sync(sync_pad[sel_reg]),
    .echo_prev(delay_pad[sel_reg]),
    .wait_en  (state_reg == WAIT_RISE),
    .meas_en  (state_reg == MEASURE),
    .rise     (rise),
    .fall     (fall),
    .timeout  (timeout),
    .overrange(overrange),
    .cm       (cm)
  );

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    err_flag_next  = err_flag_reg;
    cycle_cnt_next = cycle_cnt_reg + 16'd1;
    case (state_reg)
      IDLE: begin
        cycle_cnt_next = '0;
        if (enable) state_next = TRIG;
      end
      TRIG: begin
        if (cycle_cnt_reg == TRIG_LAST) state_next = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          state_next = MEASURE;
        end else if (timeout) begin
          state_next    = REPORT;
          err_flag_next = 1'b1;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_next    = REPORT;
          err_flag_next = 1'b0;
        end else if (overrange) begin
          state_next    = REPORT;
          err_flag_next = 1'b1;
        end
      end
      REPORT: begin
        state_next = HOLD;
      end
      HOLD: begin
        // The slot always ends on the same cycle count, so the trigger
        // period never depends on echo timing.
        if (cycle_cnt_reg == CYCLE_LAST) begin
          cycle_cnt_next = '0;
          sel_next       = (sel_reg == SEL_LAST) ? 2'd0 : sel_reg + 2'd1;
          state_next     = enable ? TRIG : IDLE;
        end
      end
      default: begin
        state_next     = IDLE;
        cycle_cnt_next = '0;
      end
    endcase
  end

  // Trigger register follows the next state, so trig is high for exactly
  // the cycles spent in TRIG.
  for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_trig
    assign trig_next[gi] = (state_next == TRIG) && (sel_next == 2'(gi));
  end

  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cycle_cnt_reg <= '0;
      sel_reg       <= '0;
      err_flag_reg  <= 1'b0;
      trig_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      cycle_cnt_reg <= cycle_cnt_next;
      sel_reg       <= sel_next;
      err_flag_reg  <= err_flag_next;
      trig_reg      <= trig_next;
    end
  end

  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      dist_cm_reg    <= '0;
      dist_sel_reg   <= '0;
      dist_valid_reg <= 1'b0;
      dist_err_reg   <= 1'b0;
    end else if (state_reg == REPORT) begin
      dist_cm_reg    <= err_flag_reg ? DIST_ERR : cm;
      dist_sel_reg   <= sel_reg;
      dist_valid_reg <= 1'b1;
      dist_err_reg   <= err_flag_reg;
    end else begin
      dist_valid_reg <= 1'b0;
      dist_err_reg   <= 1'b0;
    end
  end

  assign trig       = trig_reg;
  assign dist_cm    = dist_cm_reg;
  assign dist_sel   = dist_sel_reg;
  assign dist_valid = dist_valid_reg;
  assign dist_err   = dist_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_sonar_scheduler.sv
`timescale 1ns/1ps
module tb_sonar_scheduler;

  localparam int N    = 3;
  localparam int TRG  = 10;
  localparam int CYC  = 2700;
  localparam int RT   = 1000;
  localparam int EM   = 1500;
  localparam int UPC  = 58;
  localparam int FAR  = -1000000;

  logic           clk_1m = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [N-1:0]   echo = '0;
  logic [N-1:0]   trig;
  logic [11:0]    dist_cm;
  logic [1:0]     dist_sel;
  logic           dist_valid;
  logic           dist_err;
  logic           busy;

  sonar_scheduler #(
    .NUM_SENSORS    (N),
    .TRIG_US        (TRG),
    .CYCLE_US       (CYC),
    .RISE_TIMEOUT_US(RT),
    .ECHO_MAX_US    (EM),
    .US_PER_CM      (UPC)
  ) dut (
    .clk_1m    (clk_1m),
    .rst       (rst),
    .enable    (enable),
    .echo      (echo),
    .trig      (trig),
    .dist_cm   (dist_cm),
    .dist_sel  (dist_sel),
    .dist_valid(dist_valid),
    .dist_err  (dist_err),
    .busy      (busy)
  );

  always #5 clk_1m = ~clk_1m;

  // Number of rising clock edges so far.
  int cyc = 0;
  always @(posedge clk_1m) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model: the active slot's start edge, its sensor, and when
  // and what the result must be.
  int          m_start    = FAR;
  int          m_slot_sel = 0;
  int          m_sel      = 0;
  int          m_vt       = -1;
  logic [11:0] m_vcm      = '0;
  logic        m_verr     = 1'b0;
  logic [11:0] m_last_cm  = '0;
  int          m_last_sel = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  // Every cycle: compare all outputs with the model.
  always @(negedge clk_1m) begin
    logic [N-1:0] et;
    int off;
    off = cyc - m_start;
    et = '0;
    if (off >= 0 && off < TRG) et[m_slot_sel] = 1'b1;
    if (cyc == m_vt) begin
      m_last_cm  = m_vcm;
      m_last_sel = m_slot_sel;
    end
    check("trig", trig, et);
    check("busy", busy, (off >= 0 && off < CYC));
    check("dist_valid", dist_valid, (cyc == m_vt));
    check("dist_err", dist_err, (cyc == m_vt) && m_verr);
    check("dist_cm", dist_cm, m_last_cm);
    check("dist_sel", dist_sel, m_last_sel);
  end

  // One slot. Entered one cycle before the trigger edge. d = cycles from
  // trigger fall to raw echo rise (negative: no echo), w = echo width.
  task automatic run_slot(input int d, input int w, input bit stuck, input bit noise,
                          input int lit, input int drop_k, input int rst_k);
    int s;
    int nst[N];
    int nen[N];
    int trig_hi;
    int q;
    bit did_rst;
    logic [N-1:0] e;
    @(posedge clk_1m); #1;
    s = cyc;
    m_start = s;
    m_slot_sel = m_sel;
    if (stuck || d < 0 || d > RT - 3) begin
      // The rise reaches the timer two cycles late; later than that the
      // timeout fires first.
      m_vt = s + 11 + RT; m_vcm = 12'hFFF; m_verr = 1'b1;
    end else if (w <= EM) begin
      q = w / UPC;
      if (q > 4094) q = 4094;
      m_vt = s + 14 + d + w; m_vcm = 12'(q); m_verr = 1'b0;
    end else begin
      m_vt = s + 14 + d + EM; m_vcm = 12'hFFF; m_verr = 1'b1;
    end
    for (int j = 0; j < N; j++) begin
      if (noise && j != m_slot_sel) begin
        nst[j] = $urandom_range(2000, 20);
        nen[j] = nst[j] + $urandom_range(500, 1);
      end else begin
        nst[j] = -1;
        nen[j] = -1;
      end
    end
    trig_hi = 0;
    did_rst = 1'b0;
    for (int k = 0; k < CYC; k++) begin
      if (k > 0) begin @(posedge clk_1m); #1; end
      e = '0;
      for (int j = 0; j < N; j++) begin
        if (j == m_slot_sel) begin
          if (stuck) e[j] = (k < CYC - 5);
          else if (d >= 0) e[j] = (k >= TRG + d) && (k < TRG + d + w);
        end else begin
          e[j] = (k >= nst[j]) && (k < nen[j]);
        end
      end
      echo = e;
      if (k == drop_k) enable = 1'b0;
      if (trig[m_slot_sel]) trig_hi++;
      if (lit >= 0 && cyc == m_vt) begin
        check("lit_valid", dist_valid, 1);
        check("lit_cm", dist_cm, lit);
        check("lit_sel", dist_sel, m_slot_sel);
      end
      if (k == rst_k) begin
        #1;
        rst = 1'b1;
        enable = 1'b0;
        m_start = FAR; m_vt = -1; m_last_cm = '0; m_last_sel = 0; m_sel = 0;
        #1;
        check("rst_trig", trig, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", dist_valid, 0);
        check("rst_cm", dist_cm, 0);
        did_rst = 1'b1;
        break;
      end
    end
    if (!did_rst) begin
      m_sel = (m_sel + 1) % N;
      if (lit >= 0) check("trig_width", trig_hi, TRG);
    end
    $display("slot start=%0d sensor=%0d d=%0d w=%0d stuck=%0d result_cm=%0d err=%0d%s",
             s, m_slot_sel, d, w, stuck, m_vcm, m_verr, did_rst ? " (reset)" : "");
  endtask

  initial begin
    repeat (3) @(posedge clk_1m);
    #1;
    check("reset_trig", trig, 0);
    check("reset_busy", busy, 0);
    check("reset_cm", dist_cm, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk_1m);
    #1;
    enable = 1'b1;
    run_slot(5, 580, 0, 0, 10, -1, -1);        // sensor 0
    run_slot(3, 57, 0, 1, 0, -1, -1);          // sensor 1
    run_slot(7, 58, 0, 1, 1, -1, -1);          // sensor 2
    run_slot(-1, 0, 0, 1, 4095, -1, -1);       // no echo: timeout
    run_slot(0, 0, 1, 1, 4095, -1, -1);        // stuck high: no rise
    run_slot(100, EM, 0, 1, EM / UPC, -1, -1); // fall on overrange cycle
    run_slot(100, EM + 1, 0, 1, 4095, -1, -1); // overrange
    run_slot(RT - 3, 200, 0, 1, 3, -1, -1);    // rise on timeout cycle
    run_slot(RT - 2, 200, 0, 1, 4095, -1, -1); // rise one cycle too late
    for (int i = 0; i < 7; i++)
      run_slot($urandom_range(RT - 3, 0), $urandom_range(1600, 1), 0, 1, -1, -1, -1);
    // Sensor 1: enable dropped mid-measurement, result still reported.
    run_slot(10, 600, 0, 1, 10, TRG + 10 + 300, -1);
    echo = '0;
    repeat (300) @(posedge clk_1m);
    #1;
    enable = 1'b1;
    run_slot($urandom_range(RT - 3, 0), $urandom_range(1600, 1), 0, 1, -1, -1, -1);
    // Reset mid-measurement.
    run_slot(10, 800, 0, 1, -1, -1, TRG + 10 + 400);
    echo = '0;
    repeat (3) @(posedge clk_1m);
    #1;
    rst = 1'b0;
    @(posedge clk_1m);
    #1;
    enable = 1'b1;
    run_slot(20, 116, 0, 1, 2, CYC - 100, -1); // sensor 0 again after reset
    echo = '0;
    repeat (20) @(posedge clk_1m);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sonar_scheduler.md
Name: sonar_scheduler

Overview:
- Round-robin sequencer for up to 4 HC-SR04-style ultrasonic rangers sharing one timing datapath.
- Per sensor: issues the trigger pulse, waits for the echo rise, times the echo high width, converts it to centimetres, and reports the result with a sensor index.
- Enforces a minimum trigger-to-trigger period so ringing from one sensor cannot corrupt the next.
- Sits between the sensor pins and the distance consumers (display and game logic).

Parameters:
- NUM_SENSORS, 2, number of sensors in rotation (1..4).
- TRIG_US, 10, trigger pulse width in clk_1m cycles.
- CYCLE_US, 60000, trigger-to-trigger period per slot in cycles.
- RISE_TIMEOUT_US, 30000, maximum wait from trigger fall to echo rise.
- ECHO_MAX_US, 25000, maximum echo high time before the result is declared out of range.
- US_PER_CM, 58, echo microseconds per centimetre.

Ports:
- clk_1m  in  1  1 MHz system clock (1 cycle = 1 us).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run the rotation while high.
- echo  in  NUM_SENSORS  raw asynchronous echo inputs.
- trig  out  NUM_SENSORS  trigger outputs, registered.
- dist_cm  out  12  last distance in cm; 12'hFFF = error/out of range.
- dist_sel  out  2  sensor index of dist_cm.
- dist_valid  out  1  one-cycle strobe when dist_cm/dist_sel update.
- dist_err  out  1  one-cycle strobe coincident with dist_valid on timeout or overrange.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk_1m.
- Reset values: trig=0, dist_cm=0, dist_sel=0, dist_valid=0, dist_err=0, busy=0, state=IDLE, sel=0, all counters 0.
- Input synchronisation: each echo bit passes through a 2-FF synchroniser followed by a delay register. rise/fall = edge detect on the selected channel's synchronised echo.
- States:
  - IDLE: if enable, go to TRIG; cycle_cnt cleared.
  - TRIG: trig[sel]=1 for exactly TRIG_US cycles, then go to WAIT_RISE. cycle_cnt counts from TRIG entry.
  - WAIT_RISE: on rise, go to MEASURE with us_sub=0 and cm=0. If wait_cnt reaches RISE_TIMEOUT_US-1 without a rise, go to REPORT with error.
  - MEASURE: each cycle us_sub increments. When us_sub==US_PER_CM-1, us_sub wraps to 0 and cm increments. On fall, go to REPORT with dist=cm (floor(width/58)). If high time reaches ECHO_MAX_US, go to REPORT with error.
  - REPORT: for one cycle, register dist_cm, dist_sel=sel, dist_valid=1, and dist_err as applicable (error result sets dist_cm=12'hFFF). Then go to HOLD.
  - HOLD: wait until cycle_cnt==CYCLE_US-1. Then sel=(sel==NUM_SENSORS-1)?0:sel+1. If enable, go to TRIG, otherwise go to IDLE.
- Level versus edge: an echo already high on WAIT_RISE entry is not a rise; only a 0→1 transition counts.
- Rise and timeout on the same cycle: rise wins.
- Fall and overrange on the same cycle: fall wins (valid result).
- Echoes on non-selected channels are ignored.
- enable dropped mid-slot: the current slot completes through HOLD, then the block enters IDLE. sel still advances.
- Reset mid-operation: trig drops immediately (asynchronously); no dist_valid is emitted.
- Slot period: when enabled continuously, the slot period is exactly CYCLE_US cycles, independent of echo timing.
- Counter widths: cycle_cnt 16 bits, wait_cnt 15 bits, us_sub 6 bits, cm 12 bits. cm saturates at 12'hFFE and never produces the 12'hFFF error code in normal operation.
- Latency: dist_valid asserts 4 cycles after the raw echo falling edge (2 sync + 1 edge + 1 REPORT).

Decomposition:
- Shared package: state encoding (IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, HOLD), DIST_ERR=12'hFFF, US_PER_CM default.
- Sub-module echo_timer: one instance on the muxed, synchronised echo. It contains the edge detect, us_sub/cm counters, wait/overrange counters and start/clear controls, and outputs rise, fall, cm, timeout and overrange.
- The scheduler FSM, trigger generation and round-robin selection stay in the top-level block.

Test Plan:
- Sensor 0, echo high 580 us after trigger -> trig[0] high exactly 10 cycles; dist_cm=10, dist_sel=0, dist_valid one cycle, dist_err=0.
- Echo widths 57 us and 58 us -> dist_cm=0 and dist_cm=1 respectively.
- No echo rise -> after 30000 cycles in WAIT_RISE: dist_cm=12'hFFF, dist_err=1, and the next trigger still occurs 60000 cycles after the previous one.
- Echo stuck high (and high before trigger) -> no false rise; a rise at 100 us followed by staying high 25000 us -> dist_cm=12'hFFF, dist_err=1.
- NUM_SENSORS=3, enable held high, distinct echo widths per sensor -> trigger order 0,1,2,0 at 60000-cycle spacing; dist_sel matches; echo pulses on non-selected lines have no effect.
- enable dropped during sensor 1 MEASURE -> result still reported, busy falls after HOLD, no further triggers. rst asserted mid-MEASURE -> trig=0 and all outputs 0 immediately, no dist_valid.
